// File: rtl/ex_stage.sv
// MIPS execute stage: operand forwarding, main ALU, destination select and an optional
// iterative multiply/divide unit with HI/LO registers, built when EX_MULDIV_EN is defined.
module ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        WBin,
  input  logic [2:0]        Min,
  input  logic [3:0]        EXin,
  input  logic [DATA_W-1:0] R1DATin,
  input  logic [DATA_W-1:0] R2DATin,
  input  logic [DATA_W-1:0] SEin,
  input  logic [REG_AW-1:0] Rsin,
  input  logic [REG_AW-1:0] Rtin,
  input  logic [REG_AW-1:0] Rdin,
  input  logic              exmem_regwrite,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_regwrite,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_data,
  output logic [1:0]        WBout,
  output logic [2:0]        Mout,
  output logic [DATA_W-1:0] ALUout,
  output logic [DATA_W-1:0] R2fwd,
  output logic [REG_AW-1:0] Dstout,
  output logic              Zero,
  output logic              stall
);
  localparam int W = DATA_W;

  logic [W-1:0] rs_fwd, rt_fwd, opb, alu_res;
  logic [5:0]   funct;
  logic [4:0]   shamt;
  logic [1:0]   aluop;
  logic [W-1:0] hi_val, lo_val;

  assign funct = SEin[5:0];
  assign shamt = SEin[10:6];
  assign aluop = EXin[1:0];

  // EX/MEM wins over MEM/WB; register 0 is never forwarded.
  assign rs_fwd = (exmem_regwrite && exmem_rd != '0 && exmem_rd == Rsin) ? exmem_result :
                  (memwb_regwrite && memwb_rd != '0 && memwb_rd == Rsin) ? memwb_data : R1DATin;
  assign rt_fwd = (exmem_regwrite && exmem_rd != '0 && exmem_rd == Rtin) ? exmem_result :
                  (memwb_regwrite && memwb_rd != '0 && memwb_rd == Rtin) ? memwb_data : R2DATin;
  assign opb    = EXin[2] ? SEin : rt_fwd;
  assign R2fwd  = rt_fwd;
  assign Dstout = EXin[3] ? Rdin : Rtin;

  always_comb begin
    alu_res = '0;
    case (aluop)
      2'b00: alu_res = rs_fwd + opb;
      2'b01: alu_res = rs_fwd - opb;
      2'b11: alu_res = {{(W-1){1'b0}}, $signed(rs_fwd) < $signed(opb)};
      default: begin
        case (funct)
          6'h20, 6'h21: alu_res = rs_fwd + opb;
          6'h22, 6'h23: alu_res = rs_fwd - opb;
          6'h24: alu_res = rs_fwd & opb;
          6'h25: alu_res = rs_fwd | opb;
          6'h26: alu_res = rs_fwd ^ opb;
          6'h27: alu_res = ~(rs_fwd | opb);
          6'h2A: alu_res = {{(W-1){1'b0}}, $signed(rs_fwd) < $signed(opb)};
          6'h2B: alu_res = {{(W-1){1'b0}}, rs_fwd < opb};
          6'h00: alu_res = rt_fwd << shamt;
          6'h02: alu_res = rt_fwd >> shamt;
          6'h03: alu_res = W'($signed(rt_fwd) >>> shamt);
          6'h10: alu_res = hi_val;
          6'h12: alu_res = lo_val;
          default: alu_res = '0;
        endcase
      end
    endcase
  end

  assign ALUout = alu_res;
  assign Zero   = (alu_res == '0);
  assign WBout  = stall ? 2'b00  : WBin;
  assign Mout   = stall ? 3'b000 : Min;

`ifdef EX_MULDIV_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_e;

  md_state_e      state_q;
  logic [4:0]     cnt_q;
  logic [W-1:0]   hi_q, lo_q, opb_q, rs_q;
  logic [2*W-1:0] acc_q, acc_d, prod;
  logic           is_div_q, div0_q, qneg_q, rneg_q;
  logic           md_op, md_start, md_div, a_neg, b_neg;
  logic [W-1:0]   a_mag, b_mag, quo, rem, hi_fin, lo_fin, div_sub;
  logic [W:0]     mul_sum, div_sh;

  assign md_op    = (aluop == 2'b10) && (funct[5:2] == 4'b0110);
  assign md_start = (state_q == IDLE) && md_op;
  assign stall    = md_start || (state_q == BUSY);
  assign md_div   = funct[1];
  assign a_neg    = ~funct[0] & rs_fwd[W-1];
  assign b_neg    = ~funct[0] & rt_fwd[W-1];
  assign a_mag    = a_neg ? -rs_fwd : rs_fwd;
  assign b_mag    = b_neg ? -rt_fwd : rt_fwd;
  assign hi_val   = hi_q;
  assign lo_val   = lo_q;

  // acc_q holds {acc, multiplier} for multiply and {remainder, quotient} for divide.
  always_comb begin
    mul_sum = {1'b0, acc_q[2*W-1:W]} + ({1'b0, opb_q} & {(W+1){acc_q[0]}});
    div_sh  = {acc_q[2*W-1:W], acc_q[W-1]};
    div_sub = div_sh[W-1:0] - opb_q;
    if (is_div_q)
      acc_d = (div_sh >= {1'b0, opb_q}) ? {div_sub, acc_q[W-2:0], 1'b1}
                                        : {div_sh[W-1:0], acc_q[W-2:0], 1'b0};
    else
      acc_d = {mul_sum, acc_q[W-1:1]};
    prod   = qneg_q ? -acc_d : acc_d;
    quo    = qneg_q ? -acc_d[W-1:0] : acc_d[W-1:0];
    rem    = rneg_q ? -acc_d[2*W-1:W] : acc_d[2*W-1:W];
    hi_fin = !is_div_q ? prod[2*W-1:W] : (div0_q ? rs_q : rem);
    lo_fin = !is_div_q ? prod[W-1:0]   : (div0_q ? '1   : quo);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (md_start) begin
          state_q <= BUSY;
          cnt_q   <= '0;
        end
        BUSY: begin
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'(W-1)) begin
            hi_q    <= hi_fin;
            lo_q    <= lo_fin;
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (md_start) begin
      acc_q    <= {{W{1'b0}}, (md_div ? a_mag : b_mag)};
      opb_q    <= md_div ? b_mag : a_mag;
      is_div_q <= md_div;
      div0_q   <= (rt_fwd == '0);
      qneg_q   <= a_neg ^ b_neg;
      rneg_q   <= a_neg;
      rs_q     <= rs_fwd;
    end else if (state_q == BUSY) begin
      acc_q <= acc_d;
    end
  end
`else
  logic unused_md;
  assign unused_md = clk ^ rst;
  assign stall     = 1'b0;
  assign hi_val    = '0;
  assign lo_val    = '0;
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: table of ALU/forwarding vectors checked through a scoreboard queue,
// plus multiply/divide and mid-operation reset sequences when EX_MULDIV_EN is defined.
module tb_ex_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  WBin, WBout;
  logic [2:0]  Min, Mout;
  logic [3:0]  EXin;
  logic [31:0] R1DATin, R2DATin, SEin, exmem_result, memwb_data, ALUout, R2fwd;
  logic [4:0]  Rsin, Rtin, Rdin, exmem_rd, memwb_rd, Dstout;
  logic        exmem_regwrite, memwb_regwrite, Zero, stall;

  ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .WBin(WBin), .Min(Min), .EXin(EXin),
    .R1DATin(R1DATin), .R2DATin(R2DATin), .SEin(SEin),
    .Rsin(Rsin), .Rtin(Rtin), .Rdin(Rdin),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .WBout(WBout), .Mout(Mout), .ALUout(ALUout), .R2fwd(R2fwd),
    .Dstout(Dstout), .Zero(Zero), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  ex;
    logic [31:0] r1, r2, se;
    logic [4:0]  rs, rt, rd;
    logic        exw;
    logic [4:0]  exrd;
    logic [31:0] exres;
    logic        mww;
    logic [4:0]  mwrd;
    logic [31:0] mwdat;
    logic [31:0] alu, r2f;
    logic [4:0]  dst;
    logic        zero;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input string n, input logic [3:0] ex,
                               input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] se,
                               input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                               input logic [31:0] alu, input logic [31:0] r2f,
                               input logic [4:0] dst, input logic z);
    vec_t v;
    v.name = n; v.ex = ex; v.r1 = r1; v.r2 = r2; v.se = se;
    v.rs = rs; v.rt = rt; v.rd = rd;
    v.exw = 1'b0; v.exrd = 5'd0; v.exres = 32'd0;
    v.mww = 1'b0; v.mwrd = 5'd0; v.mwdat = 32'd0;
    v.alu = alu; v.r2f = r2f; v.dst = dst; v.zero = z;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    EXin = v.ex; R1DATin = v.r1; R2DATin = v.r2; SEin = v.se;
    Rsin = v.rs; Rtin = v.rt; Rdin = v.rd;
    exmem_regwrite = v.exw; exmem_rd = v.exrd; exmem_result = v.exres;
    memwb_regwrite = v.mww; memwb_rd = v.mwrd; memwb_data = v.mwdat;
    exp_q.push_back(v);
  endtask

  task automatic check_out();
    vec_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: got empty queue, expected one entry");
      return;
    end
    e = exp_q.pop_front();
    check({e.name, "_alu"},   ALUout, e.alu);
    check({e.name, "_r2fwd"}, R2fwd, e.r2f);
    check({e.name, "_dst"},   32'(Dstout), 32'(e.dst));
    check({e.name, "_zero"},  32'(Zero), 32'(e.zero));
    check({e.name, "_stall"}, 32'(stall), 32'd0);
    check({e.name, "_wb"},    32'(WBout), 32'(WBin));
    check({e.name, "_m"},     32'(Mout), 32'(Min));
  endtask

`ifdef EX_MULDIV_EN
  task automatic run_md(input string n, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int cyc;
    int bad;
    @(posedge clk); #1;
    EXin = 4'b1010; SEin = {26'd0, f}; R1DATin = a; R2DATin = b;
    Rsin = 5'd1; Rtin = 5'd2; Rdin = 5'd3;
    exmem_regwrite = 1'b0; memwb_regwrite = 1'b0;
    WBin = 2'b11; Min = 3'b111;
    cyc = 0;
    bad = 0;
    @(negedge clk);
    while (stall && cyc < 100) begin
      cyc++;
      if (WBout !== 2'b00 || Mout !== 3'b000) bad++;
      @(negedge clk);
    end
    check({n, "_stall_cycles"}, 32'(cyc), 32'd33);
    check({n, "_bubble"}, 32'(bad), 32'd0);
    check({n, "_retire_wb"}, 32'(WBout), 32'd3);
    check({n, "_retire_m"}, 32'(Mout), 32'd7);
    WBin = 2'b10; Min = 3'b101;
    @(posedge clk); #1;
    drive(mkv({n, "_mfhi"}, 4'b1010, 0, 0, 32'h10, 5'd1, 5'd2, 5'd3, eh, 0, 5'd3, eh == 0));
    @(negedge clk); check_out();
    @(posedge clk); #1;
    drive(mkv({n, "_mflo"}, 4'b1010, 0, 0, 32'h12, 5'd1, 5'd2, 5'd3, el, 0, 5'd3, el == 0));
    @(negedge clk); check_out();
  endtask
`endif

  initial begin
    vec_t v;
    rst = 1'b0;
    WBin = 2'b10; Min = 3'b101;
    EXin = 4'b1010; R1DATin = 0; R2DATin = 0; SEin = 32'h10;
    Rsin = 0; Rtin = 0; Rdin = 0;
    exmem_regwrite = 0; exmem_rd = 0; exmem_result = 0;
    memwb_regwrite = 0; memwb_rd = 0; memwb_data = 0;
    #12;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_wb", 32'(WBout), 32'd2);
    check("rst_mfhi", ALUout, 32'd0);
    @(negedge clk) rst = 1'b1;

    tbl.push_back(mkv("add", 4'b1010, 5, 7, 32'h20, 5'd3, 5'd4, 5'd9, 32'hC, 7, 5'd9, 0));
    v = mkv("fwd_pri_rs", 4'b1010, 5, 7, 32'h20, 5'd3, 5'd4, 5'd9, 32'h17, 7, 5'd9, 0);
    v.exw = 1; v.exrd = 5'd3; v.exres = 32'h10; v.mww = 1; v.mwrd = 5'd3; v.mwdat = 32'h20;
    tbl.push_back(v);
    v = mkv("fwd_mw_rs", 4'b1010, 5, 7, 32'h20, 5'd3, 5'd4, 5'd9, 32'h27, 7, 5'd9, 0);
    v.exrd = 5'd3; v.exres = 32'h10; v.mww = 1; v.mwrd = 5'd3; v.mwdat = 32'h20;
    tbl.push_back(v);
    v = mkv("rd0_nofwd", 4'b0100, 5, 7, 1, 5'd0, 5'd4, 5'd9, 32'h6, 7, 5'd4, 0);
    v.exw = 1; v.exrd = 5'd0; v.exres = 32'h10; v.mww = 1; v.mwrd = 5'd0; v.mwdat = 32'h20;
    tbl.push_back(v);
    v = mkv("fwd_mw_rt", 4'b1010, 5, 7, 32'h22, 5'd3, 5'd4, 5'd9, 32'hFFFFFFE5, 32'h20, 5'd9, 0);
    v.mww = 1; v.mwrd = 5'd4; v.mwdat = 32'h20;
    tbl.push_back(v);
    v = mkv("fwd_pri_rt", 4'b0100, 5, 7, 8, 5'd3, 5'd4, 5'd9, 32'hD, 32'hAA, 5'd4, 0);
    v.exw = 1; v.exrd = 5'd4; v.exres = 32'hAA; v.mww = 1; v.mwrd = 5'd4; v.mwdat = 32'hBB;
    tbl.push_back(v);
    v = mkv("exw0_rt", 4'b1010, 5, 7, 32'h25, 5'd3, 5'd4, 5'd9, 32'h7, 7, 5'd9, 0);
    v.exrd = 5'd4; v.exres = 32'hAA;
    tbl.push_back(v);
    tbl.push_back(mkv("sra", 4'b1010, 0, 32'h80000000, 32'h103, 5'd1, 5'd2, 5'd3, 32'hF8000000, 32'h80000000, 5'd3, 0));
    tbl.push_back(mkv("sll", 4'b1010, 0, 1, 32'h100, 5'd1, 5'd2, 5'd3, 32'h10, 1, 5'd3, 0));
    tbl.push_back(mkv("srl", 4'b1010, 0, 32'h80000000, 32'h102, 5'd1, 5'd2, 5'd3, 32'h08000000, 32'h80000000, 5'd3, 0));
    tbl.push_back(mkv("beq", 4'b0001, 32'h1234, 32'h1234, 0, 5'd1, 5'd2, 5'd3, 0, 32'h1234, 5'd2, 1));
    tbl.push_back(mkv("slti", 4'b0111, 32'hFFFFFFFF, 0, 1, 5'd1, 5'd2, 5'd3, 1, 0, 5'd2, 0));
    tbl.push_back(mkv("slt", 4'b1010, 32'hFFFFFFFF, 1, 32'h2A, 5'd1, 5'd2, 5'd3, 1, 1, 5'd3, 0));
    tbl.push_back(mkv("sltu", 4'b1010, 32'hFFFFFFFF, 1, 32'h2B, 5'd1, 5'd2, 5'd3, 0, 1, 5'd3, 1));
    tbl.push_back(mkv("and", 4'b1010, 32'hF0F000FF, 32'h0FF00F0F, 32'h24, 5'd1, 5'd2, 5'd3, 32'h00F0000F, 32'h0FF00F0F, 5'd3, 0));
    tbl.push_back(mkv("or", 4'b1010, 32'hF0F000FF, 32'h0FF00F0F, 32'h25, 5'd1, 5'd2, 5'd3, 32'hFFF00FFF, 32'h0FF00F0F, 5'd3, 0));
    tbl.push_back(mkv("xor", 4'b1010, 32'hF0F000FF, 32'h0FF00F0F, 32'h26, 5'd1, 5'd2, 5'd3, 32'hFF000FF0, 32'h0FF00F0F, 5'd3, 0));
    tbl.push_back(mkv("nor", 4'b1010, 32'hF0F000FF, 32'h0FF00F0F, 32'h27, 5'd1, 5'd2, 5'd3, 32'h000FF000, 32'h0FF00F0F, 5'd3, 0));
    tbl.push_back(mkv("addu_wrap", 4'b1010, 32'hFFFFFFFF, 1, 32'h21, 5'd1, 5'd2, 5'd3, 0, 1, 5'd3, 1));
    tbl.push_back(mkv("subu", 4'b1010, 3, 5, 32'h23, 5'd1, 5'd2, 5'd3, 32'hFFFFFFFE, 5, 5'd3, 0));
    tbl.push_back(mkv("bad_funct", 4'b1010, 3, 5, 32'h3F, 5'd1, 5'd2, 5'd3, 0, 5, 5'd3, 1));
    tbl.push_back(mkv("lw_addr", 4'b0100, 32'h1000, 0, 32'hFFFFFFFC, 5'd1, 5'd2, 5'd3, 32'hFFC, 0, 5'd2, 0));
    tbl.push_back(mkv("mfhi_rst", 4'b1010, 3, 5, 32'h10, 5'd1, 5'd2, 5'd3, 0, 5, 5'd3, 1));
    tbl.push_back(mkv("mflo_rst", 4'b1010, 3, 5, 32'h12, 5'd1, 5'd2, 5'd3, 0, 5, 5'd3, 1));
`ifndef EX_MULDIV_EN
    tbl.push_back(mkv("mult_off", 4'b1010, 32'hFFFFFFFE, 3, 32'h18, 5'd1, 5'd2, 5'd3, 0, 3, 5'd3, 1));
    tbl.push_back(mkv("divu_off", 4'b1010, 7, 0, 32'h1B, 5'd1, 5'd2, 5'd3, 0, 0, 5'd3, 1));
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      drive(tbl[i]);
      @(negedge clk);
      check_out();
    end

`ifdef EX_MULDIV_EN
    run_md("mult",     6'h18, 32'hFFFFFFFE, 32'h3,        32'hFFFFFFFF, 32'hFFFFFFFA);
    run_md("mult_neg", 6'h18, 32'h7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_md("divu0",    6'h1B, 32'h7,        32'h0,        32'h7,        32'hFFFFFFFF);
    run_md("div_neg",  6'h1A, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_md("div_rem",  6'h1A, 32'h7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD);
    run_md("div_ovf",  6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000);
    run_md("divu",     6'h1B, 32'd100,      32'd7,        32'd2,        32'd14);
    run_md("multu",    6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);

    // Abort a multiply partway through BUSY with an asynchronous reset.
    @(posedge clk); #1;
    EXin = 4'b1010; SEin = 32'h18; R1DATin = 5; R2DATin = 6;
    Rsin = 5'd1; Rtin = 5'd2; Rdin = 5'd3;
    @(negedge clk);
    check("abort_start_stall", 32'(stall), 32'd1);
    repeat (11) @(negedge clk);
    check("abort_busy10_stall", 32'(stall), 32'd1);
    #1 rst = 1'b0;
    #1 check("abort_stall_async", 32'(stall), 32'd0);
    SEin = 32'h10;
    #1 check("abort_hi", ALUout, 32'd0);
    SEin = 32'h12;
    #1 check("abort_lo", ALUout, 32'd0);
    @(negedge clk) rst = 1'b1;
    run_md("mult_after_rst", 6'h18, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline; consumes the ID/EX pipeline register outputs and feeds the EX/MEM register.
- Contains operand forwarding muxes, the main ALU, destination-register select, and an iterative multiply/divide unit with HI/LO registers.
- The multiply/divide unit stalls the front end while busy.

Parameters:
- DATA_W, 32, datapath width; only 32 is supported.
- REG_AW, 5, register specifier width.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- WBin  in  2  WB control {RegWrite, MemtoReg}
- Min  in  3  MEM control, passed through
- EXin  in  4  {RegDst, ALUSrc, ALUOp[1:0]}
- R1DATin  in  32  rs read data
- R2DATin  in  32  rt read data
- SEin  in  32  sign-extended immediate; [5:0] funct, [10:6] shamt
- Rsin, Rtin, Rdin  in  5 each  register specifiers
- exmem_regwrite  in  1  EX/MEM RegWrite
- exmem_rd  in  5  EX/MEM destination register
- exmem_result  in  32  EX/MEM ALU result
- memwb_regwrite  in  1  MEM/WB RegWrite
- memwb_rd  in  5  MEM/WB destination register
- memwb_data  in  32  MEM/WB writeback data
- WBout  out  2  to EX/MEM; forced 0 while stall
- Mout  out  3  to EX/MEM; forced 0 while stall
- ALUout  out  32  ALU / MFHI / MFLO result
- R2fwd  out  32  forwarded rt, used as store data
- Dstout  out  5  RegDst ? Rdin : Rtin
- Zero  out  1  ALUout == 0
- stall  out  1  freezes PC, IF/ID and ID/EX

Behaviour:
- Forwarding, applied independently to rs and rt:
  - Select exmem_result if exmem_regwrite, exmem_rd != 0 and exmem_rd matches.
  - Else select memwb_data if memwb_regwrite, memwb_rd != 0 and memwb_rd matches.
  - Else select the register-file data.
  - EX/MEM has priority when both stages match.
- Operand B = ALUSrc ? SEin : forwarded rt.
- ALUOp decode:
  - 00: add.
  - 01: sub.
  - 11: slt (signed).
  - 10: decode funct.
    - 20/21 add
    - 22/23 sub
    - 24 and
    - 25 or
    - 26 xor
    - 27 nor
    - 2A slt
    - 2B sltu
    - 00 sll, 02 srl, 03 sra (shift rt by shamt)
    - 10 mfhi
    - 12 mflo
    - 18 mult, 19 multu, 1A div, 1B divu (multiply/divide ops)
    - Any other funct gives 0.
- Arithmetic: all results wrap modulo 2^32; no overflow traps.
- ALU result and Zero are combinational; EX/MEM does the registering.
- Multiply/divide FSM states: IDLE, BUSY, DONE.
  - IDLE: on ALUOp==10 with a mult/div funct, assert stall combinationally, latch forwarded operands, and enter BUSY with count = 0.
  - BUSY: one shift-add or restoring-subtract step per cycle; stall = 1. At count 31, write HI/LO and go to DONE.
  - DONE: stall = 0 so the instruction retires; next state IDLE. The same instruction is never restarted.
  - Total occupancy: 34 cycles in EX with stall high for 33. A back-to-back multiply/divide starts on the IDLE cycle after DONE.
- Results:
  - mult/multu: HI:LO = 64-bit product.
  - div/divu: LO = quotient, HI = remainder.
  - Signed ops use magnitudes; quotient sign is sign(rs)^sign(rt), remainder takes the sign of rs.
  - Divide by zero: LO = FFFFFFFF, HI = rs.
  - 80000000 / FFFFFFFF (signed): LO = 80000000, HI = 0.
- mfhi/mflo read the HI/LO registers directly. Correctness relies on the stall; no HI/LO forwarding is needed.
- Bubble insertion: while stall = 1, WBout and Mout are 0; other outputs are don't-care.
- Reset (rst = 0, asynchronous):
  - HI = LO = 0, FSM = IDLE, count = 0, so stall = 0 immediately.
  - A reset mid-operation aborts it and leaves HI/LO at 0.
  - Combinational outputs follow their inputs.

Optional Feature:
- Macro EX_MULDIV_EN.
- Defined: the HI/LO registers and FSM are built as described above.
- Undefined:
  - No HI/LO registers or FSM; stall is tied to 0.
  - Funct 10/12/18/19/1A/1B give ALUout = 0.
  - WBout and Mout pass through unchanged.

Test Plan:
- add with rs=3 (5), rt=4 (7), no hazards -> ALUout=0000000C, Dstout=Rdin, Zero=0.
- exmem_rd=3 (result 0x10) and memwb_rd=3 (data 0x20) both match rs -> operand 0x10 used; exmem_rd=0 with exmem_regwrite=1 -> no forward.
- mult FFFFFFFE×00000003 -> stall high for 33 cycles, WBout=Mout=0 during stall; then HI=FFFFFFFF, LO=FFFFFFFA; following mfhi/mflo return those values.
- divu 7/0 -> LO=FFFFFFFF, HI=7; div FFFFFFF9(-7)/2 -> LO=FFFFFFFD, HI=FFFFFFFF.
- rst=0 asserted on BUSY cycle 10 -> stall drops without a clock edge, HI=LO=0, the next mult starts fresh with a full 34-cycle occupancy.
- sra rt=80000000 shamt=4 -> F8000000; beq (ALUOp=01) with equal operands -> Zero=1.
